// File: rtl/heroe_pkg.sv
// rtl/heroe_pkg.sv - shared game-state encoding and 7-segment constants
package heroe_pkg;

  // Game states shared with puntaje and the main FSM.
  localparam logic [2:0] OFF  = 3'd0;
  localparam logic [2:0] WLCM = 3'd1;
  localparam logic [2:0] CH   = 3'd2;
  localparam logic [2:0] GAME = 3'd3;
  localparam logic [2:0] WL   = 3'd4;
  localparam logic [2:0] PA   = 3'd5;

  // gfedcba pattern for the digit zero.
  localparam logic [6:0] SEG_ZERO = 7'b0111111;

  // One-hot digit enable for a scan index (0 hundreds, 1 tens, 2 ones).
  function automatic logic [2:0] digit_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running modulo-DIV counter with wrap tick
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high clear of the count
//   tick - high during the cycle where cnt == DIV-1 (count wraps on that edge)
//   cnt  - current count, 0..DIV-1
module tick_gen #(
  parameter int DIV = 8,
  parameter int W   = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic         clk,
  input  logic         rst,
  output logic         tick,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/display_scan.sv
// rtl/display_scan.sv - three-digit multiplexed 7-segment score driver
// Ports:
//   clk             - system clock
//   rst             - synchronous active-high reset
//   display_puntaje - {ones, tens, hundreds} gfedcba patterns, 7 bits each
//   presente        - game state (heroe_pkg encoding)
//   seg             - registered segment bus for the active digit
//   dig_en          - registered one-hot digit enable, [0] hundreds .. [2] ones
module display_scan
  import heroe_pkg::*;
#(
  parameter int SCAN_DIV   = 27000,
  parameter int DEAD       = 2700,
  parameter int BLINK_DIV  = 13500000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [20:0] display_puntaje,
  input  logic [2:0]  presente,
  output logic [6:0]  seg,
  output logic [2:0]  dig_en
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] DEAD_C = SW'(DEAD);

  logic [SW-1:0] slot_cnt;
  logic          slot_tick;
  logic [BW-1:0] blink_cnt_unused;  // only the wrap tick matters for blink
  logic          blink_tick;
  logic          blink_rst;
  logic          blk;
  logic [1:0]    idx;
  logic [20:0]   snap;
  logic          load_pend;
  logic          visible;
  logic          h_blank;
  logic          t_blank;
  logic [6:0]    digit_pat;
  logic [6:0]    seg_r;
  logic [2:0]    dig_r;

  tick_gen #(.DIV(SCAN_DIV), .W(SW)) u_slot (
    .clk  (clk),
    .rst  (rst),
    .tick (slot_tick),
    .cnt  (slot_cnt)
  );

  // Holding the blink counter clear outside WL makes every WL entry start
  // with a full visible half-period.
  assign blink_rst = rst | (presente != WL);

  tick_gen #(.DIV(BLINK_DIV), .W(BW)) u_blink (
    .clk  (clk),
    .rst  (blink_rst),
    .tick (blink_tick),
    .cnt  (blink_cnt_unused)
  );

  always_ff @(posedge clk) begin
    if (blink_rst) begin
      blk <= 1'b1;
    end else if (blink_tick) begin
      blk <= ~blk;
    end
  end

  // Digit index and per-frame snapshot. load_pend grabs the score on the
  // first cycle out of reset so the first frame is not stuck on zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= 2'd0;
      snap      <= '0;
      load_pend <= 1'b1;
    end else begin
      load_pend <= 1'b0;
      if (slot_tick) begin
        idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end
      if (load_pend || (slot_tick && idx == 2'd2)) begin
        snap <= display_puntaje;
      end
    end
  end

  assign h_blank = (snap[6:0] == SEG_ZERO);
  assign t_blank = h_blank && (snap[13:7] == SEG_ZERO);

  always_comb begin
    digit_pat = snap[20:14];
    case (idx)
      2'd0:    digit_pat = h_blank ? 7'd0 : snap[6:0];
      2'd1:    digit_pat = t_blank ? 7'd0 : snap[13:7];
      default: digit_pat = snap[20:14];
    endcase
  end

  always_comb begin
    visible = 1'b0;
    case (presente)
      WLCM, CH, GAME, PA: visible = 1'b1;
      WL:                 visible = blk;
      default:            visible = 1'b0;
    endcase
  end

  // seg leads dig_en: the pattern settles during the dead time before the
  // digit is enabled, which keeps the previous digit from ghosting.
  always_ff @(posedge clk) begin
    if (rst || !visible) begin
      seg_r <= '0;
      dig_r <= '0;
    end else begin
      seg_r <= digit_pat;
      dig_r <= (slot_cnt < DEAD_C) ? 3'b000 : digit_onehot(idx);
    end
  end

  assign seg    = ACTIVE_LOW ? ~seg_r : seg_r;
  assign dig_en = ACTIVE_LOW ? ~dig_r : dig_r;

endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - randomized self-checking bench for display_scan
module tb_display_scan;

  localparam int SCAN_DIV  = 8;
  localparam int DEAD      = 2;
  localparam int BLINK_DIV = 40;
  localparam int FRAME     = 3 * SCAN_DIV;
  localparam logic [6:0] ZERO = 7'b0111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [20:0] display_puntaje;
  logic [2:0]  presente;
  logic [6:0]  seg;
  logic [2:0]  dig_en;

  int tests = 0;
  int fails = 0;

  // Reference state: cycles since reset release, consecutive WL cycles,
  // and the score the current frame is showing.
  int          m_t   = 0;
  int          m_wl  = 0;
  logic [20:0] m_snap = '0;

  always #5 clk = ~clk;

  display_scan #(
    .SCAN_DIV   (SCAN_DIV),
    .DEAD       (DEAD),
    .BLINK_DIV  (BLINK_DIV),
    .ACTIVE_LOW (1'b0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .display_puntaje (display_puntaje),
    .presente        (presente),
    .seg             (seg),
    .dig_en          (dig_en)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seven(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      default: return 7'h6F;
    endcase
  endfunction

  function automatic logic [20:0] score(input int n);
    return {seven(n % 10), seven((n / 10) % 10), seven((n / 100) % 10)};
  endfunction

  // One clock: predict the outputs from the inputs and the reference state,
  // advance the reference, clock the DUT and compare.
  task automatic step();
    logic [6:0] e_seg;
    logic [2:0] e_dig;
    logic       vis;
    logic [6:0] h, tn, o;
    int         d, pos;
    e_seg = '0;
    e_dig = '0;
    if (rst) begin
      m_t    = 0;
      m_wl   = 0;
      m_snap = '0;
    end else begin
      case (presente)
        3'd1, 3'd2, 3'd3, 3'd5: vis = 1'b1;
        3'd4:                   vis = ((m_wl / BLINK_DIV) % 2) == 0;
        default:                vis = 1'b0;
      endcase
      d   = (m_t / SCAN_DIV) % 3;
      pos = m_t % SCAN_DIV;
      h   = m_snap[6:0];
      tn  = m_snap[13:7];
      o   = m_snap[20:14];
      if (vis) begin
        e_dig = (pos < DEAD) ? 3'b000 : 3'(1 << d);
        case (d)
          0:       e_seg = (h == ZERO) ? 7'd0 : h;
          1:       e_seg = (h == ZERO && tn == ZERO) ? 7'd0 : tn;
          default: e_seg = o;
        endcase
      end
      if (m_t == 0 || (m_t % FRAME) == FRAME - 1) m_snap = display_puntaje;
      m_t++;
      m_wl = (presente == 3'd4) ? m_wl + 1 : 0;
    end
    @(posedge clk);
    #1;
    check("seg", seg, e_seg);
    check("dig_en", dig_en, e_dig);
    check("onehot", $countones(dig_en) <= 1, 1);
  endtask

  initial begin
    rst             = 1'b1;
    presente        = 3'd3;
    display_puntaje = score(0);
    repeat (3) step();
    rst = 1'b0;
    repeat (40) step();

    display_puntaje = score(123);
    repeat (60) step();
    display_puntaje = score(5);
    repeat (60) step();
    display_puntaje = score(0);
    repeat (60) step();
    display_puntaje = score(50);
    repeat (60) step();

    // Score change in the middle of the tens slot must not tear.
    display_puntaje = score(199);
    repeat (48) step();
    while ((m_t % FRAME) != SCAN_DIV + 3) step();
    display_puntaje = score(200);
    repeat (48) step();

    // Blink: enter WL, sit through light/dark, leave mid-dark.
    presente = 3'd3;
    repeat (5) step();
    presente = 3'd4;
    repeat (130) step();
    presente = 3'd3;
    repeat (10) step();
    presente = 3'd0;
    repeat (30) step();
    presente = 3'd6;
    repeat (10) step();
    presente = 3'd7;
    repeat (10) step();
    presente = 3'd1;
    repeat (30) step();
    presente = 3'd2;
    repeat (30) step();
    presente = 3'd5;
    repeat (30) step();

    // Reset in the ones slot, slot count 5.
    presente = 3'd3;
    while ((m_t % FRAME) != 2 * SCAN_DIV + 5) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (30) step();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        presente = ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 29) == 0) begin
        display_puntaje = ($urandom_range(0, 3) == 0) ? 21'($urandom)
                                                      : score($urandom_range(0, 999));
      end
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
